// File: rtl/evenodd_sched.sv
// Round-robin owner of the shared even/odd step counter: grants one client, steps count by 2 len times, pulses done, releases.
// Latency: grant and start count are visible after the request edge, step k after edge +k, and grant drops one edge after done.
// Backpressure: requests are level-held; a client waits in IDLE while the other's burst runs, so at most one burst.
module evenodd_sched #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic             busy,
    output logic             mode,
    output logic [3:0]       count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_q;   // owner of the most recent grant; reset to odd so even wins first
    logic [LEN_W-1:0] rem_q;    // steps left in the current burst, including the one about to happen
    logic [1:0]       grant_q;
    logic [1:0]       done_q;
    logic             busy_q;
    logic             mode_q;
    logic [3:0]       count_q;

    logic             pick_vld;
    logic             pick_idx;
    logic [LEN_W-1:0] pick_len_raw;
    logic [LEN_W-1:0] pick_len;

    // Arbitration: a lone requester wins; on contention the client that did not go last wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 1'b0;
        unique case (req)
            2'b01: begin
                pick_vld = 1'b1;
                pick_idx = 1'b0;
            end
            2'b10: begin
                pick_vld = 1'b1;
                pick_idx = 1'b1;
            end
            2'b11: begin
                pick_vld = 1'b1;
                pick_idx = ~last_q;
            end
            default: begin
                pick_vld = 1'b0;
                pick_idx = 1'b0;
            end
        endcase
        pick_len_raw = pick_idx ? len1 : len0;
        // A zero length still performs one step so every grant ends with a done pulse.
        pick_len = (pick_len_raw == '0) ? LEN_W'(1) : pick_len_raw;
    end

    // Scheduler FSM: every output is a register updated here alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            rem_q   <= '0;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
            mode_q  <= 1'b0;
            count_q <= 4'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // count and mode keep the last owner's values until the next grant.
                    if (pick_vld) begin
                        state_q <= ST_RUN;
                        grant_q <= pick_idx ? 2'b10 : 2'b01;
                        mode_q  <= pick_idx;
                        count_q <= {3'b000, pick_idx};
                        last_q  <= pick_idx;
                        rem_q   <= pick_len;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Adding 2 preserves parity, so the 4-bit wrap lands on 0 (even) or 1 (odd).
                    count_q <= count_q + 4'd2;
                    rem_q   <= rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        done_q  <= grant_q;
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // The release cycle is the mandatory gap before the next owner.
                    grant_q <= 2'b00;
                    done_q  <= 2'b00;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    grant_q <= 2'b00;
                    done_q  <= 2'b00;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign mode  = mode_q;
    assign count = count_q;

endmodule

// File: tb/tb_evenodd_sched.sv
// Directed bench for evenodd_sched: single/alternating bursts, wrap, zero length, mid-burst changes, async reset.
// Latency: checks are sampled on the falling edge after each rising edge.
// Backpressure: none; the request level is driven directly from the stimulus sequence.
module tb_evenodd_sched;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] grant;
    logic [1:0] done;
    logic       busy;
    logic       mode;
    logic [3:0] count;

    int n_chk;
    int n_err;

    evenodd_sched #(.LEN_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .mode  (mode),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Follows one burst from the grant edge to the release edge; expected values come from owner/start/len.
    task automatic run_burst(input int owner, input int start, input int len,
                             input logic [1:0] req_next, input logic [3:0] len0_next,
                             input logic [3:0] len1_next);
        logic [1:0] g;
        logic [3:0] c;
        logic       m;
        g = (owner == 0) ? 2'b01 : 2'b10;
        m = (owner != 0);
        c = 4'd0;
        for (int k = 0; k <= len; k++) begin
            @(posedge clk);
            @(negedge clk);
            c = 4'((start + 2 * k) % 16);
            check("grant", 32'(grant), 32'(g));
            check("count", 32'(count), 32'(c));
            check("mode", 32'(mode), 32'(m));
            check("parity", 32'(count[0]), 32'(m));
            check("done", 32'(done), (k == len) ? 32'(g) : 32'd0);
            check("busy", 32'(busy), 32'd1);
            if (k == 0) begin
                req  = req_next;
                len0 = len0_next;
                len1 = len1_next;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("rel_grant", 32'(grant), 32'd0);
        check("rel_done", 32'(done), 32'd0);
        check("rel_busy", 32'(busy), 32'd0);
        check("rel_count", 32'(count), 32'(c));
        check("rel_mode", 32'(mode), 32'(m));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b0;
        req   = 2'b00;
        len0  = 4'd0;
        len1  = 4'd0;

        // Reset values while held in reset.
        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;

        // Idle with no request: nothing moves.
        @(posedge clk);
        @(negedge clk);
        check("idle_grant", 32'(grant), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Even burst of 3: 0,2,4,6 with done on 6; request dropped after grant.
        req  = 2'b01;
        len0 = 4'd3;
        run_burst(0, 0, 3, 2'b00, 4'd3, 4'd0);
        @(posedge clk);
        @(negedge clk);
        check("hold_grant", 32'(grant), 32'd0);
        check("hold_count", 32'(count), 32'd6);
        check("hold_mode", 32'(mode), 32'd0);

        // Odd burst of 9 wrapping 15 -> 1, done on 3.
        req  = 2'b10;
        len1 = 4'd9;
        run_burst(1, 1, 9, 2'b00, 4'd0, 4'd9);

        // Both requesting: alternate even, odd, even with one idle cycle between bursts.
        req  = 2'b11;
        len0 = 4'd2;
        len1 = 4'd2;
        run_burst(0, 0, 2, 2'b11, 4'd2, 4'd2);
        run_burst(1, 1, 2, 2'b11, 4'd2, 4'd2);
        run_burst(0, 0, 2, 2'b00, 4'd2, 4'd2);

        // Zero length acts as one step; len0 change and request drop mid-burst are ignored.
        req  = 2'b01;
        len0 = 4'd0;
        run_burst(0, 0, 1, 2'b00, 4'd7, 4'd2);

        // Async reset during an odd burst.
        req  = 2'b10;
        len1 = 4'd5;
        @(posedge clk);
        @(negedge clk);
        check("odd_grant", 32'(grant), 32'd2);
        check("odd_count", 32'(count), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("odd_step", 32'(count), 32'd3);
        #2 rst = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_mode", 32'(mode), 32'd0);
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        req  = 2'b11;
        len0 = 4'd1;
        rst  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_grant", 32'(grant), 32'd1);
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_mode", 32'(mode), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/evenodd_sched.md
# evenodd_sched

Round-robin scheduler that shares one 4-bit even/odd step counter between two requesters. Requester 0 owns the even sequence (0, 2, 4, …), and requester 1 owns the odd sequence (1, 3, 5, …). A grant loads the counter with the owner's start value, steps it by 2 a programmed number of times, pulses `done`, and releases it. The block sits between client logic and the even/odd counting datapath, and it owns the counter's `mode` and `count`.

## Interface
- `LEN_W`, default 4: width of the burst-length inputs.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `req`, input, 2: `req[0]` is the even client and `req[1]` is the odd client. Level requests.
- `len0`, input, `LEN_W`: step count for the even client, sampled at grant.
- `len1`, input, `LEN_W`: step count for the odd client, sampled at grant.
- `grant`, output, 2: one-hot owner of the counter; `2'b00` when idle.
- `done`, output, 2: one-cycle pulse on the granted client's bit during its final step.
- `busy`, output, 1: high whenever the state is not IDLE.
- `mode`, output, 1: 0 = even, 1 = odd. Follows the current or last owner.
- `count`, output, 4: counter value.

## Operation
- All outputs are registered.
- Reset values (asynchronous, while `rst`=0):
  - `count`=0, `mode`=0, `grant`=00, `done`=00, `busy`=0.
  - State is IDLE; the round-robin pointer is `last`=1, so the even client wins first.
- FSM states are IDLE, RUN and RELEASE.
- IDLE:
  - With no request, stay in IDLE; `count` and `mode` hold their last values.
  - With one request, grant that client.
  - With both requests, grant the client not equal to `last`.
  - On grant: set `grant[i]`, `mode`=i, `count`=i (0 or 1), `last`=i.
  - On grant: `remaining` = `len_i`, with `len_i`=0 treated as 1. Go to RUN.
- RUN, each edge:
  - `count` = `count` + 2 modulo 16 (natural 4-bit wrap: even 14→0, odd 15→1).
  - `remaining` decrements by 1.
  - If `remaining` was 1: assert `done[i]` and go to RELEASE.
- RELEASE: clear `grant` and `done`, go to IDLE. `count` and `mode` hold.
- Request rules:
  - Dropping `req` mid-burst does not abort; the burst always completes.
  - `len0` and `len1` changes after the grant edge are ignored.
  - A requester still asserting `req` after its own `done` is re-arbitrated normally in IDLE.
- Parity invariant: `count[0]` == `mode` at all times after the first grant.
- Reset mid-burst: all state and outputs return asynchronously to reset values. The burst is lost with no `done` pulse. The pointer returns to even-first.

## Timing
- Request latency: with `req` high at edge E (in IDLE), `grant` and the start `count` are visible after E.
- Step timing: step k (1..L) appears after edge E+k.
- `done` is high for exactly one cycle, after edge E+L, coincident with the final `count` value. `grant` is still high in that cycle.
- Release: `grant`=0 after E+L+1. The earliest next grant is after E+L+2.
- Grant period: one grant occupies L+2 cycles, including one mandatory idle cycle.
- Fairness: with both clients requesting continuously, grants alternate 0,1,0,1…. Neither client waits more than one burst.
- `busy` covers RUN and RELEASE, i.e. cycles E+1 … E+L+1 relative to visible `grant`; it is low again after E+L+1.

## Test plan
- Reset, then `req`=01, `len0`=3:
  - `count` 0,2,4,6 on consecutive cycles.
  - `done`=01 with `count`=6.
  - `grant` 01 for 4 cycles, then 00.
  - `mode`=0 throughout.
- `req`=11 held, `len0`=2, `len1`=2:
  - Grants alternate 01,10,01; sequences 0,2,4 then 1,3,5 then 4→… restart at 0,2,4.
  - One idle cycle between bursts.
- `req`=10, `len1`=9:
  - `count` 1,3,5,…,15,1,3 (wrap 15→1).
  - `done` with `count`=3; `count[0]`=1 throughout.
- `len0`=0:
  - Treated as 1: `count` 0,2, then `done`.
  - Change `len0` to 7 mid-burst: burst length unaffected.
  - Drop `req` mid-burst: burst still completes.
- Assert `rst`=0 asynchronously (between edges) during RUN of an odd burst:
  - Outputs go immediately to `count`=0, `mode`=0, `grant`=00, `done`=00, `busy`=0.
  - After release, `req`=11: grant goes to the even client first.
